// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin two-source TX scheduler that feeds the frame buffer and the framer.
// Define ETH_TX_SCHED_CRC_EN to append an IEEE 802.3 CRC32 after the padded frame.
module eth_tx_sched #(
    parameter int MIN_LEN    = 60,
    parameter int FRAME_MAX  = 244,
    parameter int IFG_CYCLES = 96,
    parameter int TX_TIMEOUT = 65535
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  req,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic [1:0]  wvalid,
    output logic [1:0]  wready,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        buf_clr,
    output logic        buf_wr,
    output logic [7:0]  buf_wdata,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam int IW = $clog2(IFG_CYCLES + 1);
    localparam logic [7:0]    MIN_B   = 8'(MIN_LEN);
    localparam logic [7:0]    MAX_B   = 8'(FRAME_MAX);
    localparam logic [TW-1:0] TMO_END = TW'(TX_TIMEOUT - 1);
    localparam logic [IW-1:0] IFG_END = IW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
`ifdef ETH_TX_SCHED_CRC_EN
        S_CRC,
`endif
        S_TX,
        S_IFG
    } state_t;

`ifdef ETH_TX_SCHED_CRC_EN
    localparam state_t S_DATA_END = S_CRC;
`else
    localparam state_t S_DATA_END = S_TX;
`endif

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          w_q, w_d;
    logic          ptr_q, ptr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          buf_clr_q, buf_clr_d;
    logic          buf_wr_q, buf_wr_d;
    logic [7:0]    buf_wdata_q, buf_wdata_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`ifdef ETH_TX_SCHED_CRC_EN
    logic [31:0]   crc_q, crc_d;
    logic [1:0]    crc_idx_q, crc_idx_d;
    logic [31:0]   crc_fin;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign crc_fin = ~crc_q;
`endif

    logic       len_ok;
    logic       hs;
    logic       win;
    logic [7:0] wbyte;

    assign len_ok = (len_q != 8'd0) && (len_q <= MAX_B);
    assign wready = (state_q == S_LOAD && len_ok) ? gnt_q : 2'b00;
    assign hs     = |(wvalid & wready);
    assign wbyte  = w_q ? wdata1 : wdata0;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        w_d         = w_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        ifg_d       = '0;
        done_d      = '0;
        err_d       = '0;
        buf_clr_d   = 1'b0;
        buf_wr_d    = 1'b0;
        buf_wdata_d = '0;
        frame_cnt_d = frame_cnt_q;
        // pointer 1 favours req[1]; pointer 0 favours req[0]
        win         = ptr_q ? req[1] : ~req[0];
`ifdef ETH_TX_SCHED_CRC_EN
        crc_d       = crc_q;
        crc_idx_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    w_d       = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    len_d     = win ? len1 : len0;
                    cnt_d     = '0;
                    buf_clr_d = 1'b1;
`ifdef ETH_TX_SCHED_CRC_EN
                    crc_d     = '1;
`endif
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!len_ok) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = S_IFG;
                end else if (hs) begin
                    buf_wr_d    = 1'b1;
                    buf_wdata_d = wbyte;
                    cnt_d       = cnt_q + 8'd1;
`ifdef ETH_TX_SCHED_CRC_EN
                    crc_d       = crc32_byte(crc_q, wbyte);
`endif
                    if (cnt_q == len_q - 8'd1)
                        state_d = (len_q < MIN_B) ? S_PAD : S_DATA_END;
                end
            end
            S_PAD: begin
                buf_wr_d = 1'b1;
                cnt_d    = cnt_q + 8'd1;
`ifdef ETH_TX_SCHED_CRC_EN
                crc_d    = crc32_byte(crc_q, 8'h00);
`endif
                if (cnt_q == MIN_B - 8'd1)
                    state_d = S_DATA_END;
            end
`ifdef ETH_TX_SCHED_CRC_EN
            S_CRC: begin
                buf_wr_d    = 1'b1;
                buf_wdata_d = crc_fin[{crc_idx_q, 3'b000} +: 8];
                crc_idx_d   = crc_idx_q + 2'd1;
                if (crc_idx_q == 2'd3)
                    state_d = S_TX;
            end
`endif
            S_TX: begin
                if (tx_done) begin
                    done_d      = gnt_q;
                    gnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_IFG;
                end else if (tmo_q == TMO_END) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_IFG: begin
                if (ifg_q == IFG_END) begin
                    ptr_d   = ~w_q;
                    state_d = S_IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            w_q         <= 1'b0;
            ptr_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ifg_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            buf_clr_q   <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_wdata_q <= '0;
            frame_cnt_q <= '0;
`ifdef ETH_TX_SCHED_CRC_EN
            crc_q       <= '1;
            crc_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            w_q         <= w_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ifg_q       <= ifg_d;
            done_q      <= done_d;
            err_q       <= err_d;
            buf_clr_q   <= buf_clr_d;
            buf_wr_q    <= buf_wr_d;
            buf_wdata_q <= buf_wdata_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef ETH_TX_SCHED_CRC_EN
            crc_q       <= crc_d;
            crc_idx_q   <= crc_idx_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign buf_clr   = buf_clr_q;
    assign buf_wr    = buf_wr_q;
    assign buf_wdata = buf_wdata_q;
    assign frame_cnt = frame_cnt_q;
    assign tx_start  = (state_q == S_TX);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Table-driven bench for eth_tx_sched: each record is one frame transaction with hand-computed results,
// followed by a mid-frame reset sequence. CRC expectations apply when ETH_TX_SCHED_CRC_EN is defined.
module tb_eth_tx_sched;
    localparam int MIN_LEN    = 60;
    localparam int IFG_CYCLES = 96;
    localparam int TX_TIMEOUT = 300;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [1:0]  req = '0;
    logic [7:0]  len0 = '0, len1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]  wvalid = '0;
    logic [1:0]  wready, gnt, done, err;
    logic        buf_clr, buf_wr, tx_start, busy;
    logic        tx_done = 1'b0;
    logic [7:0]  buf_wdata;
    logic [15:0] frame_cnt;

    always #5 HCLK = ~HCLK;

    eth_tx_sched #(
        .MIN_LEN(60), .FRAME_MAX(244), .IFG_CYCLES(IFG_CYCLES), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req(req), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1), .wvalid(wvalid), .wready(wready),
        .gnt(gnt), .done(done), .err(err), .buf_clr(buf_clr), .buf_wr(buf_wr),
        .buf_wdata(buf_wdata), .tx_start(tx_start), .tx_done(tx_done),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] len0;
        logic [7:0] len1;
        bit         gap;      // wvalid only every other cycle; tx_done held high outside TX
        int         dly;      // tx_start cycles before tx_done; 0 = never
        bit         hold;     // keep req asserted through IFG
        bit         zdata;    // all-zero payload
        logic [1:0] exp_gnt;
        bit         exp_ok;
        int         exp_wr;   // writes excluding CRC
        int         exp_txs;  // cycles with tx_start high
    } vec_t;

    vec_t        tbl[14];
    int          total = 0, bad = 0;
    int          cyc = 0;
    logic [7:0]  wq[$];
    int          n_clr, n_txs, n_done, n_err, n_gnt_ifg, first_tx, last_wr, t_end;
    logic [1:0]  last_done, last_err;
    bit          both;
    logic [15:0] fc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        cyc++;
        if (buf_wr) begin
            wq.push_back(buf_wdata);
            last_wr = cyc;
        end
        if (buf_clr) n_clr++;
        if (tx_start) begin
            if (n_txs == 0) first_tx = cyc;
            n_txs++;
        end
        if (done != 2'b00) begin n_done++; last_done = done; end
        if (err != 2'b00) begin n_err++; last_err = err; end
        if (done != 2'b00 && err != 2'b00) both = 1'b1;
        if ((done | err) != 2'b00 && t_end < 0) t_end = cyc;
        if (t_end >= 0 && gnt != 2'b00) n_gnt_ifg++;
    endtask

    function automatic logic [7:0] pat(input bit r, input int k, input bit z);
        logic [7:0] kb;
        kb = 8'(k);
        if (z) return 8'h00;
        return r ? (8'hC0 + kb) : kb;
    endfunction

`ifdef ETH_TX_SCHED_CRC_EN
    function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        return ~c;
    endfunction
`endif

    task automatic run_frame(input vec_t v, input string tag);
        int         acc0 = 0, acc1 = 0, budget = 0, nbad = 0, exp_cnt;
        logic [1:0] hs;
        logic [7:0] exp_q[$];
        bit         w;
`ifdef ETH_TX_SCHED_CRC_EN
        logic [31:0] c;
`endif
        wq.delete();
        n_clr = 0; n_txs = 0; n_done = 0; n_err = 0; n_gnt_ifg = 0;
        first_tx = -1; last_wr = -2; t_end = -1; both = 1'b0;
        last_done = '0; last_err = '0;
        req = v.req; len0 = v.len0; len1 = v.len1; wvalid = '0; tx_done = 1'b0;
        tick();
        check({tag, " gnt"}, gnt, v.exp_gnt);
        if (!v.hold) req = '0;
        while (busy && budget < 3000) begin
            wdata0  = pat(1'b0, acc0, v.zdata);
            wdata1  = pat(1'b1, acc1, v.zdata);
            wvalid  = (v.gap && cyc[0]) ? 2'b00 : 2'b11;
            tx_done = tx_start ? (v.dly > 0 && n_txs == v.dly) : v.gap;
            hs      = wvalid & wready;
            tick();
            acc0 += int'(hs[0]);
            acc1 += int'(hs[1]);
            budget++;
        end
        wvalid = '0; tx_done = 1'b0;
        if (!v.hold) req = '0;
        check({tag, " bounded"}, budget < 3000, 1);

        w = v.exp_gnt[1];
        exp_cnt = v.exp_wr;
        if (v.exp_txs > 0) begin
            for (int k = 0; k < int'(w ? v.len1 : v.len0); k++) exp_q.push_back(pat(w, k, v.zdata));
            while (exp_q.size() < MIN_LEN) exp_q.push_back(8'h00);
`ifdef ETH_TX_SCHED_CRC_EN
            c = crc_ref(exp_q);
            for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
            exp_cnt += 4;
`endif
        end
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i] !== exp_q[i]) nbad++;
        check({tag, " buf_clr"}, n_clr, 1);
        check({tag, " wr_count"}, wq.size(), exp_cnt);
        check({tag, " wr_data_bad"}, nbad, 0);
        check({tag, " tx_cycles"}, n_txs, v.exp_txs);
        check({tag, " done"}, last_done, v.exp_ok ? v.exp_gnt : 2'b00);
        check({tag, " err"}, last_err, v.exp_ok ? 2'b00 : v.exp_gnt);
        check({tag, " pulses"}, n_done + n_err, 1);
        check({tag, " done_and_err"}, both, 0);
        check({tag, " frame_cnt"}, frame_cnt, fc);
        check({tag, " ifg_len"}, cyc - t_end, IFG_CYCLES);
        check({tag, " gnt_in_ifg"}, n_gnt_ifg, 0);
        if (v.exp_txs > 0) check({tag, " tx_latency"}, first_tx, last_wr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        repeat (3) @(negedge HCLK);
        check("reset_outputs",
              {gnt, wready, done, err, buf_clr, buf_wr, buf_wdata, tx_start, busy, frame_cnt}, '0);
        HRESET = 1'b0;
        fc = '0;

        //            req    len0    len1  gap dly hold z  gnt    ok wr   txs
        tbl[0]  = '{2'b01, 8'd64,  8'd9,   0, 20, 0, 0, 2'b01, 1, 64,  20};
        tbl[1]  = '{2'b11, 8'd8,   8'd70,  0, 4,  1, 0, 2'b10, 1, 70,  4};
        tbl[2]  = '{2'b11, 8'd8,   8'd70,  1, 2,  1, 0, 2'b01, 1, 60,  2};
        tbl[3]  = '{2'b11, 8'd8,   8'd10,  0, 5,  0, 0, 2'b10, 1, 60,  5};
        tbl[4]  = '{2'b01, 8'd0,   8'd5,   0, 1,  0, 0, 2'b01, 0, 0,   0};
        tbl[5]  = '{2'b01, 8'd245, 8'd5,   0, 1,  0, 0, 2'b01, 0, 0,   0};
        tbl[6]  = '{2'b10, 8'd3,   8'd244, 1, 1,  0, 0, 2'b10, 1, 244, 1};
        tbl[7]  = '{2'b10, 8'd3,   8'd60,  0, 3,  0, 0, 2'b10, 1, 60,  3};
        tbl[8]  = '{2'b01, 8'd59,  8'd3,   0, 2,  0, 0, 2'b01, 1, 60,  2};
        tbl[9]  = '{2'b10, 8'd3,   8'd1,   1, 7,  0, 0, 2'b10, 1, 60,  7};
        tbl[10] = '{2'b01, 8'd61,  8'd3,   0, 0,  0, 0, 2'b01, 0, 61,  TX_TIMEOUT};
        tbl[11] = '{2'b11, 8'd5,   8'd200, 0, 2,  0, 0, 2'b10, 1, 200, 2};
        tbl[12] = '{2'b01, 8'd60,  8'd3,   0, 2,  0, 1, 2'b01, 1, 60,  2};
        tbl[13] = '{2'b10, 8'd3,   8'd255, 0, 1,  0, 0, 2'b10, 0, 0,   0};

        foreach (tbl[i]) begin
            if (tbl[i].exp_ok) fc = fc + 16'd1;
            run_frame(tbl[i], $sformatf("v%0d", i));
        end

        // reset in the middle of LOAD, after five bytes have been written
        wq.delete();
        req = 2'b01; len0 = 8'd30; wvalid = '0;
        tick();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            wdata0 = 8'(k); wvalid = 2'b01;
            tick();
        end
        wvalid = '0;
        check("midload writes", wq.size(), 5);
        check("midload gnt", gnt, 2'b01);
        check("midload busy", busy, 1);
        #2 HRESET = 1'b1;
        #1 check("midload reset_outputs",
                 {gnt, wready, done, err, buf_clr, buf_wr, buf_wdata, tx_start, busy, frame_cnt}, '0);
        @(negedge HCLK);
        check("midload no_pulse", {done, err}, '0);
        HRESET = 1'b0;
        fc = 16'd1;
        hv = '{2'b01, 8'd12, 8'd3, 0, 3, 0, 0, 2'b01, 1, 60, 3};
        run_frame(hv, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Two-requester transmit scheduler for the Ethernet TX path.
- Arbitrates round-robin between two byte-stream sources (CPU bridge, DMA) for the shared frame buffer.
- For the granted source it clears the buffer, loads the frame with zero padding to minimum length, and raises transmit. It then waits for frame completion and enforces an inter-frame gap.
- Sits between the AHB/DMA side and the frame buffer / Manchester transmitter, all in the HCLK domain.

Parameters:
- MIN_LEN, 60, minimum bytes written to buffer; short frames are zero-padded up to this.
- FRAME_MAX, 244, maximum accepted len (buffer holds 256 entries: 8 preamble + 248).
- IFG_CYCLES, 96, idle cycles after each frame before the next grant.
- TX_TIMEOUT, 65535, cycles to wait for tx_done before aborting.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous reset, active-high.
- req  in  2  per-requester frame request (bit i = requester i).
- len0  in  8  requester 0 frame length in bytes, sampled at grant.
- len1  in  8  requester 1 frame length in bytes, sampled at grant.
- wdata0  in  8  requester 0 byte.
- wdata1  in  8  requester 1 byte.
- wvalid  in  2  byte valid per requester.
- wready  out  2  byte accepted per requester (only the granted bit can be 1).
- gnt  out  2  one-hot grant, held from grant until done/err.
- done  out  2  one-cycle pulse: frame transmitted.
- err  out  2  one-cycle pulse: len invalid or transmit timeout.
- buf_clr  out  1  one-cycle pulse: reset buffer write pointer.
- buf_wr  out  1  buffer byte write strobe.
- buf_wdata  out  8  buffer byte.
- tx_start  out  1  transmit request level to the framer.
- tx_done  in  1  framer completion (HCLK domain), level or pulse.
- busy  out  1  FSM not in IDLE.
- frame_cnt  out  16  frames successfully sent; wraps 0xFFFF to 0.

Behaviour:
- Reset (async, HRESET=1): all outputs 0, FSM in IDLE, RR pointer favours requester 0, all counters 0. Asserting reset mid-frame aborts immediately; no done/err is issued.
- States: IDLE, LOAD, PAD, (CRC), TX, IFG.
- IDLE
  - req sampled only here. If any bit is set, the winner is the set bit at or after the pointer; with both set the pointer decides.
  - Next cycle: gnt[w]=1, len latched, buf_clr=1 for that cycle.
  - If latched len is 0 or > FRAME_MAX: pulse err[w], drop gnt, go to IFG. The pointer still advances.
- LOAD
  - wready[w]=1; wready is combinational from state and grant.
  - Each wvalid[w]&wready[w] handshake gives buf_wr=1 and buf_wdata=wdata registered one cycle later; the byte counter increments.
  - Handshake on byte len-1: go to PAD if len<MIN_LEN, else to CRC (feature on) or TX. wready drops the same cycle.
  - wvalid of the non-granted requester is ignored. Dropping req during LOAD has no effect.
- PAD: writes 0x00 each cycle (buf_wr=1) until the byte counter reaches MIN_LEN, then goes to CRC or TX.
- TX
  - tx_start=1 from entry, held until tx_done is sampled 1.
  - The cycle after tx_done: tx_start=0, done[w] pulse, frame_cnt+1, gnt=0, go to IFG.
  - If the timeout counter reaches TX_TIMEOUT first: tx_start=0, err[w] pulse, gnt=0, go to IFG, frame_cnt unchanged.
  - tx_done seen outside TX is ignored.
- IFG: counts IFG_CYCLES cycles, then returns to IDLE. The pointer is set to the requester after w.
- busy=1 in every state except IDLE.
- Minimum latency: req to gnt 1 cycle; last byte to tx_start 1 cycle (no pad, no CRC).
- done and err are never asserted together.

Optional Feature:
- Macro: ETH_TX_SCHED_CRC_EN.
- Defined:
  - An IEEE 802.3 CRC32 is computed over every byte written in LOAD and PAD: reflected, poly 0x04C11DB7, init 0xFFFFFFFF.
  - CRC state appends the complemented CRC over 4 cycles, LSB byte first, buf_wr=1 each cycle, then goes to TX.
  - Effective FRAME_MAX check is unchanged (244 + 4 = 248).
- Undefined: the CRC state and CRC logic are absent; PAD/LOAD go straight to TX.

Test Plan:
- req=01, len0=64, bytes 0x00..0x3F with wvalid held 1, tx_done pulsed 20 cycles after tx_start -> gnt=01 one cycle after req; buf_clr once; 64 buf_wr with matching data; done[0] pulse; frame_cnt=1; busy stays 1 for IFG_CYCLES more.
- req=11 asserted simultaneously twice in succession -> first grant 01, second grant 10 (round-robin); req0 gets no grant during IFG.
- len1=10, no CRC -> 10 data writes then 50 writes of 0x00 (60 total), then tx_start; with CRC_EN, 64 writes total.
- len0=0 and, separately, len0=245 -> err[0] pulse, no buf_wr, no tx_start, frame_cnt unchanged.
- tx_done held 0 -> tx_start drops after TX_TIMEOUT cycles; err pulse; FSM passes IFG, then IDLE.
- HRESET pulsed mid-LOAD after 5 bytes -> all outputs 0 asynchronously; a later req=01 is granted normally, with buf_clr.
- CRC_EN, 60-byte frame of 0x00 -> appended bytes match a reference CRC32 computed over those 60 bytes.
